tdo_uart_tx: RTL

- Return-path block for the scan chain: monitors the chain's returned clock (RTCK) and data (TDO) and packs the TDO bits into bytes.
- Buffers the bytes in a small FIFO and sends them off-chip as asynchronous 8N1 serial. This is the transmit counterpart of the serial receive path that recovers the bit clock.
- Sits in the top-level beside the scan controller, tapping the last stage of the chain, and drives a spare output pin.

---
 rtl/tdo_uart_tx_if.sv | 24 ++
 rtl/tdo_uart_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdo_uart_tx_if.sv
// Signal bundle between the scan return path and the serial transmitter:
// sampled scan inputs and control towards the block, serial/status outputs back.
interface tdo_uart_tx_if #(
    parameter int LVL_W = 3
);
    logic             rtck;
    logic             tdo;
    logic             capture_en;
    logic             clear_overflow;
    logic             tx;
    logic             busy;
    logic             overflow;
    logic [LVL_W-1:0] fifo_level;

    modport master (
        output rtck, tdo, capture_en, clear_overflow,
        input  tx, busy, overflow, fifo_level
    );

    modport slave (
        input  rtck, tdo, capture_en, clear_overflow,
        output tx, busy, overflow, fifo_level
    );
endinterface

// File: rtl/tdo_uart_tx.sv
// Packs TDO bits sampled on RTCK rising edges into bytes, queues them in a
// small FIFO and sends them out as asynchronous 8N1 (or 8N2) serial frames.
module tdo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    tdo_uart_tx_if.slave bus
);
    localparam int               PTR_W       = $clog2(FIFO_DEPTH);
    localparam int               LVL_W       = PTR_W + 1;
    localparam logic [7:0]       BAUD_RELOAD = 8'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);
    localparam logic [2:0]       STOP_LAST   = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    logic             rtck_meta_q, rtck_sync_q, rtck_prev_q;
    logic             tdo_meta_q, tdo_sync_q;
    logic [7:0]       asm_q, asm_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             rise_s, push_s;
    logic [7:0]       byte_s;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             pop_s, full_s, wr_en_s;
    logic [7:0]       head_s;

    state_e           state_q, state_d;
    logic [7:0]       baud_q, baud_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    // Two-flop synchronizers with equal depth keep tdo aligned with rtck.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rtck_meta_q <= 1'b0;
            rtck_sync_q <= 1'b0;
            rtck_prev_q <= 1'b0;
            tdo_meta_q  <= 1'b0;
            tdo_sync_q  <= 1'b0;
        end else begin
            rtck_meta_q <= bus.rtck;
            rtck_sync_q <= rtck_meta_q;
            rtck_prev_q <= rtck_sync_q;
            tdo_meta_q  <= bus.tdo;
            tdo_sync_q  <= tdo_meta_q;
        end
    end

    // Byte assembly: LSB-first shift, push on the eighth captured bit.
    always_comb begin
        rise_s    = rtck_sync_q & ~rtck_prev_q;
        byte_s    = {tdo_sync_q, asm_q[7:1]};
        asm_d     = asm_q;
        bit_cnt_d = bit_cnt_q;
        push_s    = 1'b0;
        if (!bus.capture_en) begin
            bit_cnt_d = 3'd0;
        end else if (rise_s) begin
            asm_d     = byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            push_s    = (bit_cnt_q == 3'd7);
        end else begin
            asm_d = asm_q;
        end
    end

    // Assembly register and bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_q     <= 8'd0;
            bit_cnt_q <= 3'd0;
        end else begin
            asm_q     <= asm_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // FIFO control; a pop in the same cycle frees the slot for a push into a full FIFO.
    always_comb begin
        head_s  = mem_q[rd_ptr_q];
        pop_s   = (state_q == S_IDLE) && (level_q != {LVL_W{1'b0}});
        full_s  = (level_q == LVL_FULL);
        wr_en_s = push_s && (!full_s || pop_s);
        level_d = level_q + LVL_W'(wr_en_s) - LVL_W'(pop_s);
        if (push_s && !wr_en_s) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO storage, pointers, level and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= {LVL_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= byte_s;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            baud_q  <= 8'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Transmit FSM next state; the baud counter reloads on every advance, so no drift.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                idx_d = 3'd0;
                if (pop_s) begin
                    state_d = S_START;
                    baud_d  = BAUD_RELOAD;
                    shift_d = head_s;
                end else begin
                    baud_d = 8'd0;
                end
            end
            S_START: begin
                if (baud_q == 8'd0) begin
                    state_d = S_DATA;
                    baud_d  = BAUD_RELOAD;
                    idx_d   = 3'd0;
                end else begin
                    baud_d = baud_q - 8'd1;
                end
            end
            S_DATA: begin
                if (baud_q == 8'd0) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 8'd1;
                end
            end
            S_STOP: begin
                if (baud_q == 8'd0) begin
                    baud_d = BAUD_RELOAD;
                    if (idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered tx aligns with the state.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Registered serial and busy outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = level_q;

endmodule
